// File: rtl/tfe_latency_probe.sv
// Interval probe: timestamps a start pulse, measures the distance to the matching stop,
// flags intervals of a full timestamp period or more, and keeps saturating totals of accepted results.
module tfe_latency_probe #(
    parameter int TIME_W = 34,
    parameter int ACC_W  = 48,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TIME_W-1:0] i_time,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_clear,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [TIME_W-1:0] o_elapsed,
    output logic              o_ovf,
    output logic              o_busy,
    output logic [ACC_W-1:0]  o_total,
    output logic [CNT_W-1:0]  o_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t            state;
    logic [TIME_W-1:0] start_reg;

    logic [TIME_W-1:0] elapsed_next;
    logic              wrapped;
    logic              handshake;
    logic [ACC_W:0]    total_sum;
    logic [ACC_W-1:0]  total_next;
    logic [CNT_W-1:0]  count_next;

    // Modular subtraction gives the interval directly, including across timestamp wrap.
    // Any return of i_time to start_reg while running means a full period has elapsed.
    always_comb begin
        elapsed_next = i_time - start_reg;
        wrapped      = (i_time == start_reg);
        handshake    = (state == HOLD) && i_ready;
    end

    // One extra accumulator bit catches the carry so the total clamps instead of wrapping.
    always_comb begin
        total_sum  = {1'b0, o_total} + (ACC_W + 1)'(o_elapsed);
        total_next = total_sum[ACC_W] ? '1 : total_sum[ACC_W-1:0];
        count_next = (&o_count) ? o_count : o_count + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            start_reg <= '0;
            o_valid   <= 1'b0;
            o_elapsed <= '0;
            o_ovf     <= 1'b0;
            o_busy    <= 1'b0;
            o_total   <= '0;
            o_count   <= '0;
        end else if (i_clear) begin
            // Clear wins over everything, including a pending handshake.
            state   <= IDLE;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_ovf   <= 1'b0;
            o_total <= '0;
            o_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        start_reg <= i_time;
                        o_ovf     <= 1'b0;
                        o_busy    <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (wrapped) begin
                        o_ovf <= 1'b1;
                    end
                    if (i_stop) begin
                        o_elapsed <= elapsed_next;
                        o_valid   <= 1'b1;
                        o_busy    <= 1'b0;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        o_valid <= 1'b0;
                        o_total <= total_next;
                        o_count <= count_next;
                        state   <= IDLE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
